mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch port and the load/store (MEM-stage) data port of the pipelined MIPS core.
- Sits between `mips` and the memory model.
- Arbitrates requests, latches the winning request, and holds it on the memory bus until the memory acknowledges.
- Returns read data with a one-cycle done pulse to the owner; a watchdog aborts hung transactions.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the load/store port.
// Data wins from idle; a completing transfer hands the bus straight to the other waiting port.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              err_sticky
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam bit               WdogEn = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CntMax = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_sticky_q;

    logic busy, timeout_hit, complete;
    logic grant_fetch, grant_data;

    assign busy        = (state_q != StIdle);
    // Abort on the TIMEOUT-th consecutive cycle without mem_ready.
    assign timeout_hit = WdogEn && busy && !mem_ready && (cnt_q == CntMax);
    assign complete    = busy && (mem_ready || timeout_hit);

    assign mem_req    = busy;
    assign mem_we     = (state_q == StBusyD) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    assign i_done     = complete && (state_q == StBusyI);
    assign d_done     = complete && (state_q == StBusyD);
    assign i_rdata    = (i_done && mem_ready) ? mem_rdata : '0;
    assign d_rdata    = (d_done && mem_ready && !we_q) ? mem_rdata : '0;
    assign err        = timeout_hit;
    assign err_sticky = err_sticky_q;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;

        // The completing port's req is still high in its done cycle, so it is not looked at.
        unique case (state_q)
            StIdle: begin
                grant_data  = d_req;
                grant_fetch = i_req && !d_req;
            end
            StBusyI: begin
                if (complete) begin
                    grant_data = d_req;
                    if (!d_req) state_d = StIdle;
                end
            end
            StBusyD: begin
                if (complete) begin
                    grant_fetch = i_req;
                    if (!i_req) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (WdogEn && busy && !mem_ready && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (grant_data) begin
            state_d = StBusyD;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            cnt_d   = '0;
        end else if (grant_fetch) begin
            state_d = StBusyI;
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            err_sticky_q <= err_sticky_q | timeout_hit;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of grants, wait states, aborts and memory contents.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          i_done, d_done, mem_req, mem_we, err, err_sticky;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err),
        .err_sticky(err_sticky)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_read(logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic test_reset();
        rst = 1; i_req = 1; d_req = 1; d_we = 1; i_addr = 32'h44; d_addr = 32'h88;
        d_wdata = 32'hFFFF_FFFF; mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, i_done, d_done, err, err_sticky} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {mem_req, mem_we, i_done, d_done, err, err_sticky});
        end
        checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        idle_inputs();
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_fetch_only();
        i_req = 1; i_addr = 32'h0000_0040;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++; $display("FAIL fetch_c0_req got=%b exp=0", mem_req);
        end
        next_cyc();
        for (int k = 1; k <= 3; k++) begin
            mem_ready = (k == 3);
            mem_rdata = (k == 3) ? 32'h2008_0005 : 32'hBAD0_0000 + 32'(k);
            #1;
            checks++;
            if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
                failures++;
                $display("FAIL fetch_bus c%0d got=%b/%b/%h exp=1/0/40", k, mem_req, mem_we, mem_addr);
            end
            checks++;
            if ({i_done, d_done} !== {k == 3, 1'b0}) begin
                failures++;
                $display("FAIL fetch_done c%0d got=%b%b exp=%b0", k, i_done, d_done, k == 3);
            end
            if (k == 3) begin
                checks++;
                if (i_rdata !== 32'h2008_0005 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_rdata got=%h err=%b exp=20080005 err=0", i_rdata, err);
                end
            end
            next_cyc();
        end
        i_req = 0; mem_ready = 0;
        #1;
        checks++;
        if ({mem_req, i_done} !== 2'b00) begin
            failures++; $display("FAIL fetch_idle got=%b%b exp=00", mem_req, i_done);
        end
        next_cyc();
    endtask

    task automatic test_contention();
        i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 1;
        next_cyc();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) d_req = 0;
            mem_rdata = 32'hA000 + 32'(k);
            #1;
            checks++;
            if ({d_done, i_done} !== {k % 2 == 0, k % 2 == 1} || mem_req !== 1'b1) begin
                failures++;
                $display("FAIL contend_order t%0d got=d%b i%b req%b exp=d%b i%b req1",
                         k, d_done, i_done, mem_req, k % 2 == 0, k % 2 == 1);
            end
            checks++;
            if (mem_addr !== ((k % 2 == 0) ? 32'h300 : 32'h200)) begin
                failures++; $display("FAIL contend_addr t%0d got=%h", k, mem_addr);
            end
            next_cyc();
        end
        i_req = 0; mem_ready = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++; $display("FAIL contend_idle got=%b exp=0", mem_req);
        end
        next_cyc();
    endtask

    task automatic test_simultaneous();
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        mem_ready = 1; mem_rdata = 32'hFFFF_0000;
        next_cyc();
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h80, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL simul_write_bus got=%b/%h/%h exp=1/80/deadbeef", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({d_done, i_done, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL simul_d_done got=%b%b rd=%h exp=10 rd=0", d_done, i_done, d_rdata);
        end
        next_cyc();
        d_req = 0; mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            failures++;
            $display("FAIL simul_fetch_bus got=%b/%b/%h exp=1/0/100", mem_req, mem_we, mem_addr);
        end
        checks++;
        if ({i_done, i_rdata} !== {1'b1, 32'h1234_5678}) begin
            failures++; $display("FAIL simul_i_done got=%b/%h exp=1/12345678", i_done, i_rdata);
        end
        next_cyc();
        i_req = 0; mem_ready = 0;
        next_cyc();
    endtask

    task automatic test_watchdog();
        d_req = 1; d_we = 0; d_addr = 32'h44; mem_ready = 0; mem_rdata = 32'hCAFE_F00D;
        next_cyc();
        for (int k = 1; k <= TO; k++) begin
            #1;
            checks++;
            if ({mem_req, d_done, err, err_sticky} !== {1'b1, k == TO, k == TO, 1'b0}) begin
                failures++;
                $display("FAIL wdog c%0d got=req%b done%b err%b st%b exp=req1 done%b err%b st0",
                         k, mem_req, d_done, err, err_sticky, k == TO, k == TO);
            end
            if (k == TO) begin
                checks++;
                if (d_rdata !== 32'h0) begin
                    failures++; $display("FAIL wdog_rdata got=%h exp=0", d_rdata);
                end
            end
            next_cyc();
        end
        d_req = 0; i_req = 1; i_addr = 32'h48; mem_ready = 1; mem_rdata = 32'h0000_0055;
        #1;
        checks++;
        if ({mem_req, d_done, err, err_sticky} !== 4'b0001) begin
            failures++;
            $display("FAIL wdog_after got=req%b done%b err%b st%b exp=req0 done0 err0 st1",
                     mem_req, d_done, err, err_sticky);
        end
        next_cyc();
        #1;
        checks++;
        if ({i_done, i_rdata, err, err_sticky} !== {1'b1, 32'h55, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL wdog_fetch got=%b/%h/%b/%b exp=1/55/0/1", i_done, i_rdata, err, err_sticky);
        end
        next_cyc();
        i_req = 0; mem_ready = 0;
        next_cyc();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 1; d_addr = 32'h90; d_wdata = 32'h1111_2222; mem_ready = 0;
        next_cyc();
        #1;
        checks++;
        if ({mem_req, err_sticky} !== 2'b11) begin
            failures++; $display("FAIL rstmid_pre got=%b%b exp=11", mem_req, err_sticky);
        end
        #2 rst = 1;
        #1 mem_ready = 1;
        #1;
        checks++;
        if ({mem_req, mem_we, d_done, err_sticky} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_async got=%b%b%b%b exp=0000", mem_req, mem_we, d_done, err_sticky);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({mem_req, d_done} !== 2'b00) begin
            failures++; $display("FAIL rstmid_held got=%b%b exp=00", mem_req, d_done);
        end
        rst = 0; d_req = 0; mem_ready = 0; i_req = 1; i_addr = 32'h60;
        next_cyc();
        mem_ready = 1; mem_rdata = 32'h6060_6060;
        #1;
        checks++;
        if ({mem_req, mem_addr, i_done, i_rdata} !== {1'b1, 32'h60, 1'b1, 32'h6060_6060}) begin
            failures++;
            $display("FAIL rstmid_fetch got=%b/%h/%b/%h exp=1/60/1/60606060",
                     mem_req, mem_addr, i_done, i_rdata);
        end
        next_cyc();
        i_req = 0; mem_ready = 0;
        next_cyc();
    endtask

    task automatic test_random();
        int          owner = 0;  // 0 none, 1 fetch, 2 data
        int          nr = 0, wait_left = 0;
        bit          i_pend = 0, d_pend = 0, sticky = 0;
        bit          norm, abort, exp_i, exp_d, new_grant;
        logic [31:0] cur_addr = 0, cur_wdata = 0, rd_drv, exp_rd;
        logic        cur_we = 0;
        for (int cyc = 0; cyc < 440; cyc++) begin
            if (!i_pend) begin
                i_req = 0;
                if (cyc < 400 && $urandom_range(0, 2) == 0) begin
                    i_pend = 1; i_req = 1; i_addr = 32'($urandom_range(0, 63)) << 2;
                end
            end
            if (!d_pend) begin
                d_req = 0;
                if (cyc < 400 && $urandom_range(0, 2) == 0) begin
                    d_pend = 1; d_req = 1; d_we = 1'($urandom_range(0, 1));
                    d_addr = 32'($urandom_range(0, 63)) << 2; d_wdata = $urandom;
                end
            end
            if (owner != 0) begin
                mem_ready = (wait_left == 0);
                rd_drv = mem_ready ? mem_read(cur_addr) : $urandom;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                rd_drv = $urandom;
            end
            mem_rdata = rd_drv;
            #1;
            norm  = (owner != 0) && mem_ready;
            abort = (owner != 0) && !mem_ready && (nr == TO - 1);
            exp_i = (norm || abort) && owner == 1;
            exp_d = (norm || abort) && owner == 2;
            checks++;
            if (mem_req !== (owner != 0)) begin
                failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, mem_req, owner != 0);
            end
            if (owner != 0) begin
                checks++;
                if (mem_addr !== cur_addr || mem_we !== cur_we || (cur_we && mem_wdata !== cur_wdata)) begin
                    failures++;
                    $display("FAIL rnd_bus cyc=%0d got=%h/%b/%h exp=%h/%b/%h",
                             cyc, mem_addr, mem_we, mem_wdata, cur_addr, cur_we, cur_wdata);
                end
            end
            checks++;
            if ({i_done, d_done, err, err_sticky} !== {exp_i, exp_d, abort, sticky}) begin
                failures++;
                $display("FAIL rnd_status cyc=%0d got=i%b d%b e%b s%b exp=i%b d%b e%b s%b", cyc,
                         i_done, d_done, err, err_sticky, exp_i, exp_d, abort, sticky);
            end
            if (exp_i) begin
                exp_rd = abort ? 32'h0 : rd_drv;
                checks++;
                if (i_rdata !== exp_rd) begin
                    failures++; $display("FAIL rnd_i_rdata cyc=%0d got=%h exp=%h", cyc, i_rdata, exp_rd);
                end
            end
            if (exp_d) begin
                exp_rd = (abort || cur_we) ? 32'h0 : rd_drv;
                checks++;
                if (d_rdata !== exp_rd) begin
                    failures++; $display("FAIL rnd_d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, exp_rd);
                end
            end
            new_grant = 0;
            if (norm || abort) begin
                if (norm && cur_we) mem_model[cur_addr] = cur_wdata;
                if (abort) sticky = 1;
                if (owner == 1) begin
                    i_pend = 0; owner = d_pend ? 2 : 0;
                end else begin
                    d_pend = 0; owner = i_pend ? 1 : 0;
                end
                new_grant = (owner != 0);
            end else if (owner != 0) begin
                nr++; wait_left--;
            end else if (d_pend) begin
                owner = 2; new_grant = 1;
            end else if (i_pend) begin
                owner = 1; new_grant = 1;
            end
            if (new_grant) begin
                cur_addr  = (owner == 2) ? d_addr : i_addr;
                cur_we    = (owner == 2) ? d_we : 1'b0;
                cur_wdata = d_wdata;
                nr        = 0;
                wait_left = $urandom_range(0, 5);
            end
            next_cyc();
        end
        idle_inputs();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++; $display("FAIL rnd_drain got=%b exp=0", mem_req);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_contention();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
